// File: rtl/key_sched_pkg.sv
// Shared types for the key debounce scheduler: FSM states, FIFO event record
// and the key-index width helper.
package key_sched_pkg;

  localparam int KEY_W_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_COMMIT
  } state_t;

  typedef struct packed {
    logic [KEY_W_MAX-1:0] key;
    logic                 press;
  } evt_t;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO; a push while full is dropped unless a pop frees a
// slot in the same cycle, and the drop is flagged for one cycle.
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge sclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_debounce_scheduler.sv
// Debounces N_KEYS inputs with one shared timer granted round-robin; confirmed
// level changes are queued as press/release events.
module key_debounce_scheduler
  import key_sched_pkg::*;
#(
  parameter int   N_KEYS     = 4,
  parameter int   T_DEB      = 160000,
  parameter int   CNT_W      = 18,
  parameter logic IDLE_LVL   = 1'b1,
  parameter int   FIFO_DEPTH = 4
) (
  input  logic                      sclk,
  input  logic                      rst_n,
  input  logic [N_KEYS-1:0]         key_in,
  output logic [N_KEYS-1:0]         key_level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_key,
  output logic                      evt_press,
  output logic                      evt_overflow,
  output logic                      busy
);

  localparam int                 IDX_W  = idx_w(N_KEYS);
  localparam logic [IDX_W:0]     N_K    = (IDX_W+1)'(N_KEYS);
  localparam logic [CNT_W-1:0]   T_LAST = CNT_W'(T_DEB - 1);

  logic [N_KEYS-1:0] sync1, sync2, req, level_nx;
  state_t            state, state_nx;
  logic [IDX_W-1:0]  g, g_nx, last, last_nx, grant;
  logic [IDX_W:0]    sum;
  logic [CNT_W-1:0]  timer, timer_nx;
  logic              push;
  evt_t              push_evt, head;
  logic              empty, full;
  logic              unused_bits;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {N_KEYS{IDLE_LVL}};
      sync2 <= {N_KEYS{IDLE_LVL}};
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign req = sync2 ^ key_level;

  // Walk offsets from N down to 1 so the nearest requester after last wins.
  always_comb begin
    grant = last;
    sum   = '0;
    for (int i = N_KEYS; i >= 1; i--) begin
      sum = {1'b0, last} + (IDX_W+1)'(i);
      if (sum >= N_K) sum = sum - N_K;
      if (req[sum[IDX_W-1:0]]) grant = sum[IDX_W-1:0];
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      g         <= '0;
      last      <= IDX_W'(N_KEYS - 1);
      timer     <= '0;
      key_level <= {N_KEYS{IDLE_LVL}};
    end else begin
      state     <= state_nx;
      g         <= g_nx;
      last      <= last_nx;
      timer     <= timer_nx;
      key_level <= level_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    g_nx           = g;
    last_nx        = last;
    timer_nx       = timer;
    level_nx       = key_level;
    push           = 1'b0;
    push_evt       = '0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          g_nx     = grant;
          timer_nx = '0;
          state_nx = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (sync2[g] == key_level[g]) begin
          timer_nx = '0;
          last_nx  = g;
          state_nx = ST_IDLE;
        end else if (timer == T_LAST) begin
          state_nx = ST_COMMIT;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      ST_COMMIT: begin
        level_nx[g]    = sync2[g];
        push           = 1'b1;
        push_evt.key   = KEY_W_MAX'(g);
        push_evt.press = (sync2[g] != IDLE_LVL);
        last_nx        = g;
        state_nx       = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(evt_t))
  ) u_fifo (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt_ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .drop      (evt_overflow)
  );

  assign evt_valid   = !empty;
  assign evt_key     = head.key[IDX_W-1:0];
  assign evt_press   = head.press;
  assign busy        = (state != ST_IDLE);
  assign unused_bits = ^{full, head.key};

endmodule
